// File: rtl/unified_mem_arbiter_if.sv
// Bundle of requester-side (fetch, data) and memory-side signals around unified_mem_arbiter.
// slave = arbiter view, master = processor/memory environment view.
interface unified_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_done;
    logic            if_stall;

    logic [1:0]      d_command;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_done;
    logic            d_stall;

    logic [1:0]      mem_command;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_command, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_command, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_command, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_command, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one unified memory port between fetch and data requesters (data wins) with a
// fixed-latency IDLE/ISSUE/WAIT transaction FSM. Optional ARB_PERF_CNT_EN adds perf counters.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_if_stall_cyc,
    output logic [31:0]          perf_d_stall_cyc,
    output logic [31:0]          perf_xact_cnt
`endif
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            gnt_data_q, gnt_data_d;
    logic [1:0]      mem_command_q, mem_command_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;

    logic            d_valid;
    logic            if_stall;
    logic            d_stall;

    // 2'b11 is not a real command and is never granted.
    assign d_valid  = (bus.d_command == `BUS_LOAD) || (bus.d_command == `BUS_STORE);
    assign if_stall = bus.if_req && !if_done_q;
    assign d_stall  = d_valid && !d_done_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        gnt_data_d    = gnt_data_q;
        mem_command_d = `BUS_NONE;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_done_d     = 1'b0;
        d_done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A requester whose done is high now is still holding the finished request.
                if (d_valid && !d_done_q) begin
                    gnt_data_d    = 1'b1;
                    cmd_d         = bus.d_command;
                    mem_addr_d    = bus.d_addr;
                    mem_wdata_d   = bus.d_wdata;
                    mem_command_d = bus.d_command;
                    cnt_d         = CNT_W'(MEM_LATENCY);
                    state_d       = ISSUE;
                end else if (bus.if_req && !if_done_q) begin
                    gnt_data_d    = 1'b0;
                    cmd_d         = `BUS_LOAD;
                    mem_addr_d    = bus.if_addr;
                    mem_wdata_d   = '0;
                    mem_command_d = `BUS_LOAD;
                    cnt_d         = CNT_W'(MEM_LATENCY);
                    state_d       = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                // The issue cycle is the first latency cycle, so done lands MEM_LATENCY after it.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (gnt_data_q) begin
                        d_done_d = 1'b1;
                        if (cmd_q == `BUS_LOAD) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_q         <= `BUS_NONE;
            gnt_data_q    <= 1'b0;
            mem_command_q <= `BUS_NONE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= XLEN'(`NOOP_INST);
            d_rdata_q     <= '0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            gnt_data_q    <= gnt_data_d;
            mem_command_q <= mem_command_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_done_q     <= if_done_d;
            d_done_q      <= d_done_d;
        end
    end

    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_done     = if_done_q;
    assign bus.if_stall    = if_stall;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_done      = d_done_q;
    assign bus.d_stall     = d_stall;
    assign bus.mem_command = mem_command_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [2:0] perf_inc;
    assign perf_inc = {if_done_q | d_done_q, d_stall, if_stall};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] pcnt_q, pcnt_d;
        always_comb begin
            pcnt_d = pcnt_q;
            if (perf_inc[gi] && (pcnt_q != 32'hFFFF_FFFF)) begin
                pcnt_d = pcnt_q + 32'd1;
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_d;
            end
        end
    end

    assign perf_if_stall_cyc = g_perf[0].pcnt_q;
    assign perf_d_stall_cyc  = g_perf[1].pcnt_q;
    assign perf_xact_cnt     = g_perf[2].pcnt_q;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized requesters
// checked every cycle against a transaction-level model of the arbiter and a memory model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int          L       = 2;
    localparam int          XLEN    = 32;
    localparam logic [1:0]  B_NONE  = 2'd0;
    localparam logic [1:0]  B_LOAD  = 2'd1;
    localparam logic [1:0]  B_STORE = 2'd2;
    localparam logic [31:0] NOOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    unified_mem_arbiter_if #(.XLEN(XLEN)) bus();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] p_if, p_d, p_x;
`endif

    unified_mem_arbiter #(.MEM_LATENCY(L), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall_cyc (p_if),
        .perf_d_stall_cyc  (p_d),
        .perf_xact_cnt     (p_x)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int t      = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          rd_pend_cyc = -100;
    logic [31:0] rd_pend_addr = '0;

    // Transaction-level model: one transaction in flight, granted at cycle g, done at g+1+L.
    bit          busy = 1'b0;
    int          g = 0;
    bit          g_is_d = 1'b0;
    logic [1:0]  g_cmd = B_NONE;
    logic [31:0] g_addr = '0, g_wdata = '0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_ird = NOOP, e_drd = '0;
    bit          e_idone = 1'b0, e_ddone = 1'b0;
    int          e_pif = 0, e_pd = 0, e_px = 0;

    function automatic int widx(logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        t++;
        bus.mem_rdata = $urandom;
    endtask

    task automatic cycle_end();
        logic [1:0] e_cmd;
        bit d_el, i_el, free;
        @(negedge clk);
        e_cmd = B_NONE;
        if (rst) begin
            busy = 1'b0; e_idone = 1'b0; e_ddone = 1'b0;
            e_addr = '0; e_wdata = '0; e_ird = NOOP; e_drd = '0;
        end else begin
            e_idone = busy && !g_is_d && (t == g + 1 + L);
            e_ddone = busy &&  g_is_d && (t == g + 1 + L);
            if (e_idone) e_ird = ref_mem[widx(g_addr)];
            if (e_ddone && g_cmd == B_LOAD) e_drd = ref_mem[widx(g_addr)];
            if (busy && t == g + 1) begin
                e_cmd   = g_cmd;
                e_addr  = g_addr;
                e_wdata = g_wdata;
                if (g_cmd == B_STORE) ref_mem[widx(g_addr)] = g_wdata;
            end
        end
        chk("if_done",     32'(bus.if_done),     32'(e_idone));
        chk("d_done",      32'(bus.d_done),      32'(e_ddone));
        chk("if_stall",    32'(bus.if_stall),    32'(bus.if_req && !e_idone));
        chk("d_stall",     32'(bus.d_stall),
            32'((bus.d_command == B_LOAD || bus.d_command == B_STORE) && !e_ddone));
        chk("mem_command", 32'(bus.mem_command), 32'(e_cmd));
        chk("mem_addr",    bus.mem_addr,         e_addr);
        chk("mem_wdata",   bus.mem_wdata,        e_wdata);
        chk("if_rdata",    bus.if_rdata,         e_ird);
        chk("d_rdata",     bus.d_rdata,          e_drd);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if",     p_if, 32'(e_pif));
        chk("perf_d",      p_d,  32'(e_pd));
        chk("perf_x",      p_x,  32'(e_px));
`endif
        if (rst) begin
            e_pif = 0; e_pd = 0; e_px = 0;
        end else begin
            free = !busy || (t == g + 1 + L);
            if (free) begin
                busy = 1'b0;
                d_el = (bus.d_command == B_LOAD || bus.d_command == B_STORE) && !e_ddone;
                i_el = bus.if_req && !e_idone;
                if (d_el) begin
                    busy = 1'b1; g = t; g_is_d = 1'b1; g_cmd = bus.d_command;
                    g_addr = bus.d_addr; g_wdata = bus.d_wdata;
                end else if (i_el) begin
                    busy = 1'b1; g = t; g_is_d = 1'b0; g_cmd = B_LOAD;
                    g_addr = bus.if_addr; g_wdata = '0;
                end
            end
            e_pif += int'(bus.if_req && !e_idone);
            e_pd  += int'((bus.d_command == B_LOAD || bus.d_command == B_STORE) && !e_ddone);
            e_px  += int'(e_idone || e_ddone);
        end
        // Memory: read data is only valid in the second half of cycle cmd+L-1.
        if (bus.mem_command == B_LOAD) begin
            rd_pend_cyc  = t + L - 1;
            rd_pend_addr = bus.mem_addr;
        end
        if (bus.mem_command == B_STORE) mem[widx(bus.mem_addr)] = bus.mem_wdata;
        if (t == rd_pend_cyc) bus.mem_rdata = mem[widx(rd_pend_addr)];
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end();
        end
    endtask

    initial begin
        bit if_active = 1'b0, d_active = 1'b0;
        int d_bogus = 0, rst_cnt = 0, r;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[16] = 32'h0050_0093;
        mem[17] = 32'h0040_0113;
        mem[32] = 32'h1234_5678;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_command = B_NONE; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;

        // Reset values
        step(2);
        chk("rst_mem_command", 32'(bus.mem_command), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0000_0013);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);

        // Single fetch
        cycle_begin(); rst = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h40; cycle_end();
        chk("t1_stall_T0", 32'(bus.if_stall), 32'd1);
        step(1);
        chk("t1_cmd_T1", 32'(bus.mem_command), 32'd1);
        chk("t1_addr_T1", bus.mem_addr, 32'h40);
        step(1);
        chk("t1_stall_T2", 32'(bus.if_stall), 32'd1);
        step(1);
        chk("t1_done_T3", 32'(bus.if_done), 32'd1);
        chk("t1_rdata_T3", bus.if_rdata, 32'h0050_0093);
        cycle_begin(); bus.if_req = 1'b0; cycle_end();
        chk("t4_no_reissue", 32'(bus.mem_command), 32'd0);
        step(3);

        // Simultaneous requests: data first, fetch granted in the d_done cycle
        cycle_begin(); rst = 1'b1; cycle_end();
        cycle_begin(); rst = 1'b0;
        bus.d_command = B_LOAD; bus.d_addr = 32'h80;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        cycle_end();
        step(2);
        step(1);
        chk("t2_d_done_T3", 32'(bus.d_done), 32'd1);
        chk("t2_d_rdata_T3", bus.d_rdata, 32'h1234_5678);
        cycle_begin(); bus.d_command = B_NONE; cycle_end();
        chk("t2_cmd_T4", 32'(bus.mem_command), 32'd1);
        chk("t2_addr_T4", bus.mem_addr, 32'h44);
        step(2);
        chk("t2_if_done_T6", 32'(bus.if_done), 32'd1);
        chk("t2_if_rdata_T6", bus.if_rdata, 32'h0040_0113);
        cycle_begin(); bus.if_req = 1'b0; cycle_end();
`ifdef ARB_PERF_CNT_EN
        chk("t2_perf_xact", p_x, 32'd2);
        chk("t2_perf_d_stall", p_d, 32'd3);
        chk("t2_perf_if_stall", p_if, 32'd6);
`endif
        step(2);

        // Store
        cycle_begin(); bus.d_command = B_STORE; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF; cycle_end();
        step(1);
        chk("t3_cmd_T1", 32'(bus.mem_command), 32'd2);
        chk("t3_addr_T1", bus.mem_addr, 32'h100);
        chk("t3_wdata_T1", bus.mem_wdata, 32'hDEAD_BEEF);
        step(2);
        chk("t3_d_done_T3", 32'(bus.d_done), 32'd1);
        chk("t3_wdata_T3", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t3_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        cycle_begin(); bus.d_command = B_NONE; cycle_end();
        step(2);

        // Reset mid-transaction
        cycle_begin(); bus.if_req = 1'b1; bus.if_addr = 32'h48; cycle_end();
        step(1);
        cycle_begin(); rst = 1'b1; cycle_end();
        chk("t5_rst_cmd", 32'(bus.mem_command), 32'd0);
        chk("t5_rst_addr", bus.mem_addr, 32'd0);
        chk("t5_rst_if_rdata", bus.if_rdata, 32'h0000_0013);
        cycle_begin(); rst = 1'b0; bus.if_req = 1'b0; cycle_end();
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t5_no_done", 32'(bus.if_done), 32'd0);
        end
        cycle_begin(); bus.if_req = 1'b1; bus.if_addr = 32'h40; cycle_end();
        step(3);
        chk("t5_after_done", 32'(bus.if_done), 32'd1);
        cycle_begin(); bus.if_req = 1'b0; cycle_end();

        // Reserved command encoding
        for (int i = 0; i < 5; i++) begin
            cycle_begin(); bus.d_command = 2'b11; cycle_end();
            chk("t6_cmd_none", 32'(bus.mem_command), 32'd0);
            chk("t6_no_stall", 32'(bus.d_stall), 32'd0);
        end
        cycle_begin(); bus.d_command = B_NONE; cycle_end();
        step(2);

        // Randomized requesters against the model
        for (int c = 0; c < 4000; c++) begin
            cycle_begin();
            if (rst_cnt > 0) begin
                rst = 1'b1;
                rst_cnt--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 199) == 0) begin
                    rst = 1'b1;
                    rst_cnt = $urandom_range(0, 1);
                end
            end
            if (if_active && e_idone) begin
                if_active = 1'b0;
                bus.if_req = 1'b0;
            end
            if (!if_active && $urandom_range(0, 2) == 0) begin
                if_active = 1'b1;
                bus.if_req = 1'b1;
                bus.if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (d_active && e_ddone) begin
                d_active = 1'b0;
                bus.d_command = B_NONE;
            end
            if (d_bogus > 0) begin
                d_bogus--;
                if (d_bogus == 0) bus.d_command = B_NONE;
            end else if (!d_active && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    bus.d_command = 2'b11;
                    d_bogus = $urandom_range(1, 5);
                end else begin
                    d_active = 1'b1;
                    bus.d_command = (r < 6) ? B_LOAD : B_STORE;
                    bus.d_addr = 32'($urandom_range(0, 255)) << 2;
                    bus.d_wdata = $urandom;
                end
            end
            cycle_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
